// File: rtl/sram_tile_loader.sv
// Single-tile SRAM buffer controller: streams a tile into the macro, then reads it
// back in address order through a 2-entry skid buffer that covers the read latency.
module sram_tile_loader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              sram_cs,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    // The macro's 16-bit mode packs bytes differently; this controller cannot drive it.
    if (DATA_W == 16) begin : g_unsupported_width
        $error("sram_tile_loader: DATA_W == 16 is not supported");
    end

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t            state;
    logic [ADDR_W:0]   len;
    logic [ADDR_W:0]   issued;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_pending;
    logic [1:0]        count;
    logic [DATA_W-1:0] fifo_q [2];

    logic              in_fire;
    logic              out_fire;
    logic              issue;
    logic              last_wr;
    logic [2:0]        occ_next;

    assign in_ready  = (state == LOAD);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign out_valid = (count != 2'd0);
    assign out_data  = fifo_q[0];

    always_comb begin
        in_fire  = (state == LOAD) && in_valid;
        out_fire = out_valid && out_ready;
        // Occupancy after this cycle's pending push and pop; a new read may only
        // be issued if its data will still have a slot when it returns.
        occ_next = {1'b0, count} + {2'b00, rd_pending} - {2'b00, out_fire};
        issue    = (state == DRAIN) && (issued < len) && (occ_next < 3'd2);
        last_wr  = (({1'b0, wr_addr} + (ADDR_W+1)'(1)) == len);

        sram_cs   = in_fire || issue;
        sram_we   = in_fire;
        sram_addr = in_fire ? wr_addr : rd_addr;
        sram_din  = in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            len        <= '0;
            issued     <= '0;
            wr_addr    <= '0;
            rd_addr    <= '0;
            rd_pending <= 1'b0;
            count      <= '0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
        end else begin
            if (rd_pending) begin
                if (out_fire) begin
                    if (count == 2'd2) begin
                        fifo_q[0] <= fifo_q[1];
                        fifo_q[1] <= sram_dout;
                    end else begin
                        fifo_q[0] <= sram_dout;
                    end
                end else if (count == 2'd0) begin
                    fifo_q[0] <= sram_dout;
                end else begin
                    fifo_q[1] <= sram_dout;
                end
            end else if (out_fire) begin
                fifo_q[0] <= fifo_q[1];
            end
            count      <= occ_next[1:0];
            rd_pending <= issue;

            case (state)
                IDLE: begin
                    if (start) begin
                        len     <= load_len;
                        wr_addr <= '0;
                        state   <= (load_len == '0) ? DONE : LOAD;
                    end
                end
                LOAD: begin
                    if (in_fire) begin
                        wr_addr <= wr_addr + ADDR_W'(1);
                        if (last_wr) begin
                            state   <= DRAIN;
                            rd_addr <= '0;
                            issued  <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (issue) begin
                        rd_addr <= rd_addr + ADDR_W'(1);
                        issued  <= issued + (ADDR_W+1)'(1);
                    end
                    if ((issued == len) && !rd_pending && (count == 2'd0)) begin
                        state <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
        !(rd_pending && !out_fire && (count == 2'd2)));

endmodule

// File: tb/tb_sram_tile_loader.sv
// Scoreboard bench for sram_tile_loader with a behavioural 1-cycle-latency SRAM.
module tb_sram_tile_loader;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   load_len = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          sram_cs;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_dout;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          done;

    sram_tile_loader #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .load_len(load_len),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .sram_cs(sram_cs), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_din(sram_din), .sram_dout(sram_dout),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [1<<AW];
    always @(posedge clk) begin
        if (sram_cs && sram_we) mem[sram_addr] <= sram_din;
        if (sram_cs && !sram_we) sram_dout <= mem[sram_addr];
    end

    logic [31:0] cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // rmode: 0 = always ready, 1 = fixed irregular pattern, 2 = held off
    int          rmode = 0;
    logic [15:0] pat = 16'b1011_0010_1110_0101;
    assign out_ready = (rmode == 0) || ((rmode == 1) && pat[cyc[3:0]]);

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [DW-1:0] exp_q[$];
    int wr_idx = 0, tile_rd = 0, tile_pops = 0, cs_total = 0, rdy_seen = 0, done_cnt = 0;
    logic [31:0] first_pop_cyc = 0, last_pop_cyc = 0;

    // Monitor: scoreboard pops and per-cycle protocol checks
    always @(negedge clk) begin
        if (rst_n) begin
            if (start && !busy) begin
                exp_q.delete();
                wr_idx = 0; tile_rd = 0; tile_pops = 0;
            end
            if (sram_cs) cs_total++;
            if (in_ready) rdy_seen++;
            if (done) done_cnt++;
            if (in_ready && !in_valid) check("stall_cs", {31'b0, sram_cs}, 0);
            if (sram_cs && sram_we) begin
                check("wr_addr", {28'b0, sram_addr}, wr_idx);
                wr_idx++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", out_data, 32'hDEAD_BEEF);
                end else begin
                    check("out_data", out_data, exp_q.pop_front());
                end
                if (tile_pops == 0) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
                tile_pops++;
            end
            if (sram_cs && !sram_we) begin
                tile_rd++;
                check("outstanding_le2", {31'b0, (tile_rd - tile_pops) <= 2}, 1);
            end
        end
    end

    logic [DW-1:0] stim [16];

    task automatic start_tile(input int n);
        start = 1'b1;
        load_len = n[AW:0];
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic push_word(input logic [DW-1:0] d, input int gap);
        int n = 0;
        exp_q.push_back(d);
        in_valid = 1'b1;
        in_data = d;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", {31'b0, in_ready}, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_done(input int n);
        int t = 0;
        int base = done_cnt;
        @(negedge clk);
        while (!done && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("done_seen", {31'b0, done}, 1);
        check("busy_in_done", {31'b0, busy}, 1);
        @(negedge clk);
        check("done_once", done_cnt - base, 1);
        check("busy_after_done", {31'b0, busy}, 0);
        check("pops", tile_pops, n);
        check("queue_empty", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic run_tile(input int n, input int gap, input int mode);
        rmode = mode;
        start_tile(n);
        for (int i = 0; i < n; i++) push_word(stim[i], gap);
        wait_done(n);
    endtask

    initial begin
        int t;
        int base_cs;
        int base_rdy;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_in_ready", {31'b0, in_ready}, 0);
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_cs", {31'b0, sram_cs}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic 4-word tile, back-to-back input, consumer always ready
        stim[0] = 32'h11; stim[1] = 32'h22; stim[2] = 32'h33; stim[3] = 32'h44;
        run_tile(4, 0, 0);
        check("t1_wr_count", wr_idx, 4);
        check("t1_consecutive", last_pop_cyc - first_pop_cyc, 3);

        // Full depth, input stalls every other cycle, irregular backpressure
        for (int i = 0; i < 16; i++) stim[i] = 32'hC0DE_0000 + 32'(i * 17);
        run_tile(16, 1, 1);
        check("t2_wr_count", wr_idx, 16);
        check("t2_rd_count", tile_rd, 16);

        // Backpressure held during drain
        stim[0] = 32'hA1; stim[1] = 32'hB2; stim[2] = 32'hC3; stim[3] = 32'hD4;
        rmode = 2;
        start_tile(4);
        for (int i = 0; i < 4; i++) push_word(stim[i], 0);
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("t3_out_valid_seen", {31'b0, out_valid}, 1);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check("t3_hold_valid", {31'b0, out_valid}, 1);
            check("t3_hold_data", out_data, 32'hA1);
            check("t3_hold_cs", {31'b0, sram_cs}, 0);
            @(negedge clk);
        end
        check("t3_reads_held", tile_rd, 2);
        rmode = 0;
        wait_done(4);

        // Zero-length tile
        base_cs = cs_total;
        base_rdy = rdy_seen;
        run_tile(0, 0, 0);
        check("t4_no_cs", cs_total - base_cs, 0);
        check("t4_no_in_ready", rdy_seen - base_rdy, 0);

        // Asynchronous reset mid-drain, then a fresh 3-word tile
        for (int i = 0; i < 8; i++) stim[i] = 32'h5500 + 32'(i);
        rmode = 0;
        start_tile(8);
        for (int i = 0; i < 8; i++) push_word(stim[i], 0);
        t = 0;
        @(negedge clk);
        while (tile_pops < 2 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("t5_two_pops", tile_pops, 2);
        check("t5_mid_drain", {31'b0, busy}, 1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_busy", {31'b0, busy}, 0);
        check("t5_rst_out_valid", {31'b0, out_valid}, 0);
        check("t5_rst_in_ready", {31'b0, in_ready}, 0);
        check("t5_rst_cs", {31'b0, sram_cs}, 0);
        check("t5_rst_done", {31'b0, done}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        stim[0] = 32'h77; stim[1] = 32'h88; stim[2] = 32'h99;
        run_tile(3, 0, 0);
        check("t5_wr_count", wr_idx, 3);

        // start during LOAD must not change the tile length
        stim[0] = 32'hE1; stim[1] = 32'hE2; stim[2] = 32'hE3;
        rmode = 0;
        start_tile(3);
        push_word(stim[0], 0);
        start = 1'b1;
        load_len = 5'd5;
        @(posedge clk); #1;
        start = 1'b0;
        push_word(stim[1], 0);
        push_word(stim[2], 0);
        wait_done(3);
        check("t6_wr_count", wr_idx, 3);
        check("t6_rd_count", tile_rd, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
